ifetch_fsm: RTL and testbench
=============================

IFETCH_FSM -- requirements
Module: ifetch_fsm

Interface
REQ-001 Parameter: ALIGN_CHECK, default 1, enables the misaligned-fetch fault when 1.
REQ-002 Parameter: FAULT_INSTR, default 32'h0000_0013, the instruction word driven with instr_fault.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc_addr  input  32  current PC value, driven by the PC register's out_addr.
REQ-006 pc_load  output  1  drives the PC load enable; when 0, the PC increments by 4 on the next edge.
REQ-007 pc_load_addr  output  32  address loaded into the PC when pc_load=1.
REQ-008 req_valid  output  1  memory read request valid.
REQ-009 req_ready  input  1  memory accepts the request.
REQ-010 req_addr  output  32  memory read address.
REQ-011 rsp_valid  input  1  memory response valid; always accepted, no backpressure.
REQ-012 rsp_data  input  32  response instruction word.
REQ-013 rsp_err  input  1  bus error on the response.
REQ-014 instr_valid  output  1  instruction available for decode.
REQ-015 instr_ready  input  1  decode consumes the instruction.
REQ-016 instr  output  32  instruction word.
REQ-017 instr_pc  output  32  address of instr.
REQ-018 instr_fault  output  1  fetch fault (misaligned address or bus error).
REQ-019 redirect_valid  input  1  branch/jump redirect from execute.
REQ-020 redirect_addr  input  32  redirect target.

Function
REQ-021 States SHALL be IDLE, REQ, WAIT, HOLD and DROP.
REQ-022 IDLE: lasts one cycle after reset release, then moves to REQ; pc_load=1 with pc_load_addr=pc_addr (hold).
REQ-023 REQ: req_valid=1 and req_addr=pc_addr; stay in REQ while req_ready=0.
REQ-024 REQ on handshake (req_valid & req_ready): latch pc_addr into fetch_pc, drive pc_load=0 so the PC steps +4, then move to WAIT.
REQ-025 In every state and cycle other than the REQ handshake cycle, pc_load=1 and pc_load_addr=pc_addr, so the PC holds.
REQ-026 WAIT: on rsp_valid, register rsp_data into instr, fetch_pc into instr_pc and rsp_err into instr_fault, then move to HOLD.
REQ-027 On an rsp_err response, instr SHALL be FAULT_INSTR.
REQ-028 HOLD: instr_valid=1 and outputs stable; on instr_ready, move to REQ on the next cycle; latency is minimum 3 cycles per instruction.
REQ-029 Misalignment (ALIGN_CHECK=1, pc_addr[1:0]!=0) in REQ: req_valid=0, no memory access, move to HOLD with instr_fault=1, instr=FAULT_INSTR, instr_pc=pc_addr, and the PC held.
REQ-030 redirect_valid SHALL override all PC control: pc_load=1 and pc_load_addr=redirect_addr in that cycle.
REQ-031 redirect_valid SHALL clear instr_valid from the next cycle.
REQ-032 After a redirect, the next state SHALL be REQ, except DROP when a request is outstanding (in WAIT without rsp_valid, or a REQ handshake in the same cycle).
REQ-033 Redirect while in WAIT with rsp_valid in the same cycle: discard the response and move to REQ.
REQ-034 DROP: discard the next rsp_valid (no instr_valid), then move to REQ; a further redirect while in DROP stays in DROP with the new PC load.
REQ-035 instr_valid SHALL never assert in IDLE, REQ, WAIT or DROP.
REQ-036 Only one memory request SHALL be outstanding at any time.

Reset
REQ-037 Reset SHALL force: state IDLE; req_valid, instr_valid, instr_fault = 0; instr, instr_pc, fetch_pc = 0.
REQ-038 pc_load SHALL be 1 during reset; reset mid-transaction abandons the in-flight response without a DROP phase (memory is reset together).

Structure
REQ-039 Package ifetch_pkg SHALL hold the state enum ifetch_state_e and the constant NOP_INSTR = 32'h0000_0013.
REQ-040 The block SHALL be a single module with one registered FSM plus an output register; no sub-module.

Verification
REQ-041 PC at 32'h8000_0000, req_ready=1, rsp one cycle later with 32'h00500093, instr_ready=1 -> instr_valid with instr 32'h00500093 and instr_pc 32'h8000_0000; next req_addr 32'h8000_0004.
REQ-042 req_ready held 0 for 5 cycles -> req_addr stable, PC unchanged, pc_load=1 on each of those cycles.
REQ-043 Redirect to 32'h8000_0100 while in WAIT, then stale rsp 32'hDEADBEEF -> no instr_valid for the stale word; next req_addr 32'h8000_0100.
REQ-044 Redirect to 32'h8000_0102 -> instr_valid, instr_fault=1, instr 32'h0000_0013, instr_pc 32'h8000_0102, no req_valid.
REQ-045 rsp_err=1 -> instr_fault=1, instr = FAULT_INSTR; instr_ready=0 for 4 cycles -> outputs held, no new request.
REQ-046 Reset asserted in WAIT -> outputs reach reset values asynchronously; one IDLE cycle after release, then req_valid.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Purpose: shared types and constants for the instruction-fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   ifetch_state_e : fetch FSM state encoding
//   NOP_INSTR      : canonical no-op word, used as the default fault filler
package ifetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,  // one settling cycle after reset release
    REQ  = 3'd1,  // presenting a read request for pc_addr
    WAIT = 3'd2,  // request accepted, waiting for the response
    HOLD = 3'd3,  // instruction (or fault) presented to decode
    DROP = 3'd4   // flushing a response made stale by a redirect
  } ifetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifetch_fsm.sv
// Purpose: single-outstanding instruction fetch sequencer between PC register, memory and decode.
// Latency: minimum 3 cycles per instruction (REQ handshake -> WAIT response -> HOLD consume).
// Backpressure: holds req_valid while req_ready=0, holds instr stable while instr_ready=0; responses always accepted.
//
// Ports:
//   clk, reset                       : clock, async active-high reset
//   pc_addr / pc_load / pc_load_addr : PC register interface (PC steps +4 when pc_load=0)
//   req_valid/req_ready/req_addr     : memory read request
//   rsp_valid/rsp_data/rsp_err       : memory read response (no backpressure)
//   instr_valid/instr_ready/instr/instr_pc/instr_fault : decode interface
//   redirect_valid/redirect_addr     : branch/jump redirect from execute
module ifetch_fsm
  import ifetch_pkg::*;
#(
  parameter int          ALIGN_CHECK = 1,
  parameter logic [31:0] FAULT_INSTR = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_addr,
  output logic        pc_load,
  output logic [31:0] pc_load_addr,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr
);

  ifetch_state_e r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_instr;
  logic [31:0]   r_instr_pc;
  logic          r_instr_valid;
  logic          r_instr_fault;

  logic          w_in_req;
  logic          w_misaligned;
  logic          w_req_fire;

  assign w_in_req     = (r_state == REQ);
  assign w_misaligned = (ALIGN_CHECK != 0) && (pc_addr[1:0] != 2'b00);
  // A misaligned PC never reaches memory; it is turned into a fault locally.
  assign w_req_fire   = w_in_req && !w_misaligned && req_ready;

  assign req_valid = w_in_req && !w_misaligned;
  assign req_addr  = pc_addr;

  // The PC only advances on the accepted-request cycle; a redirect overrides
  // everything, including that step. Reset forces IDLE, so pc_load is 1 then.
  assign pc_load      = redirect_valid || !w_req_fire;
  assign pc_load_addr = redirect_valid ? redirect_addr : pc_addr;

  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_fault = r_instr_fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_fetch_pc    <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_instr_fault <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= REQ;
        end

        REQ: begin
          if (redirect_valid) begin
            // A request accepted in the redirect cycle is already in flight,
            // so its response must be flushed before fetching again.
            r_state <= w_req_fire ? DROP : REQ;
          end else if (w_misaligned) begin
            r_state       <= HOLD;
            r_instr_valid <= 1'b1;
            r_instr_fault <= 1'b1;
            r_instr       <= FAULT_INSTR;
            r_instr_pc    <= pc_addr;
          end else if (w_req_fire) begin
            r_fetch_pc <= pc_addr;
            r_state    <= WAIT;
          end
        end

        WAIT: begin
          if (rsp_valid) begin
            if (redirect_valid) begin
              // Response and redirect together: the word is stale, drop it here.
              r_state <= REQ;
            end else begin
              r_state       <= HOLD;
              r_instr_valid <= 1'b1;
              r_instr_fault <= rsp_err;
              r_instr       <= rsp_err ? FAULT_INSTR : rsp_data;
              r_instr_pc    <= r_fetch_pc;
            end
          end else if (redirect_valid) begin
            r_state <= DROP;
          end
        end

        HOLD: begin
          if (redirect_valid || instr_ready) begin
            r_state       <= REQ;
            r_instr_valid <= 1'b0;
          end
        end

        DROP: begin
          // Further redirects only reload the PC; leave once the stale
          // response has been absorbed (even if it coincides with a redirect).
          if (rsp_valid) begin
            r_state <= REQ;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_fsm.sv
// Purpose: self-checking bench for ifetch_fsm: directed scenarios then randomized traffic.
// Latency: n/a (testbench).
// Backpressure: randomized req_ready / instr_ready and response delays from a memory model.
module tb_ifetch_fsm;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] FAULT_W  = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] pc_addr;
  logic        pc_load;
  logic [31:0] pc_load_addr;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic        redirect_valid;
  logic [31:0] redirect_addr;

  ifetch_fsm dut (
    .clk            (clk),
    .reset          (reset),
    .pc_addr        (pc_addr),
    .pc_load        (pc_load),
    .pc_load_addr   (pc_load_addr),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_fault    (instr_fault),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register in the environment: load when pc_load, else step by 4.
  always @(posedge clk or posedge reset) begin
    if (reset) pc_addr <= RESET_PC;
    else       pc_addr <= pc_load ? pc_load_addr : pc_addr + 32'd4;
  end

  int checks;
  int errors;
  int delivered;

  // Transaction-level reference: accepted requests tagged with the redirect
  // epoch they belong to, and the instructions decode is owed, in order.
  typedef struct { logic [31:0] addr; int epoch; } req_t;
  typedef struct { logic [31:0] word; logic [31:0] pc; logic fault; } dlv_t;

  req_t        m_pend[$];
  dlv_t        m_dlv[$];
  int          m_epoch;
  logic [31:0] m_next_fetch;
  logic        m_first;

  // Memory environment for the random phase.
  logic mem_busy;
  int   mem_delay;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend.delete();
    m_dlv.delete();
    m_epoch      = 0;
    m_next_fetch = RESET_PC;
    m_first      = 1'b1;
    mem_busy     = 1'b0;
    mem_delay    = 0;
  endtask

  // Called just after inputs are applied; checks this cycle against the
  // reference, then advances the reference by what the coming edge commits.
  task automatic sample();
    logic free, mis, exp_rv, hs, exp_load;
    req_t r;
    dlv_t d;
    #1;
    free   = !m_first && (m_pend.size() == 0) && (m_dlv.size() == 0);
    mis    = (m_next_fetch[1:0] != 2'b00);
    exp_rv = free && !mis;
    if (free) chk("pc", pc_addr, m_next_fetch);
    chk("req_valid", {31'd0, req_valid}, {31'd0, exp_rv});
    if (exp_rv) chk("req_addr", req_addr, m_next_fetch);
    hs       = exp_rv && req_ready;
    exp_load = redirect_valid || !hs;
    chk("pc_load", {31'd0, pc_load}, {31'd0, exp_load});
    if (exp_load) chk("pc_load_addr", pc_load_addr, redirect_valid ? redirect_addr : pc_addr);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, (m_dlv.size() != 0)});
    if (m_dlv.size() != 0) begin
      chk("instr", instr, m_dlv[0].word);
      chk("instr_pc", instr_pc, m_dlv[0].pc);
      chk("instr_fault", {31'd0, instr_fault}, {31'd0, m_dlv[0].fault});
    end

    // memory environment
    if (rsp_valid) mem_busy = 1'b0;
    else if (mem_busy && mem_delay > 0) mem_delay--;
    if (req_valid && req_ready) begin
      mem_busy  = 1'b1;
      mem_delay = $urandom_range(0, 3);
    end

    // reference update
    if (m_dlv.size() != 0 && (redirect_valid || instr_ready)) begin
      if (!redirect_valid) delivered++;
      void'(m_dlv.pop_front());
    end
    if (rsp_valid && m_pend.size() != 0) begin
      r = m_pend.pop_front();
      if (r.epoch == m_epoch && !redirect_valid) begin
        d.word  = rsp_err ? FAULT_W : rsp_data;
        d.pc    = r.addr;
        d.fault = rsp_err;
        m_dlv.push_back(d);
      end
    end
    if (hs) begin
      chk("one_outstanding", m_pend.size(), 0);
      r.addr  = m_next_fetch;
      r.epoch = m_epoch;
      m_pend.push_back(r);
      m_next_fetch = m_next_fetch + 32'd4;
    end
    if (free && mis && !redirect_valid) begin
      d.word  = FAULT_W;
      d.pc    = m_next_fetch;
      d.fault = 1'b1;
      m_dlv.push_back(d);
    end
    if (redirect_valid) begin
      m_epoch++;
      m_next_fetch = redirect_addr;
    end
    m_first = 1'b0;
  endtask

  task automatic idle_inputs();
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_data       = 32'd0;
    rsp_err        = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'd0;
  endtask

  task automatic drive_random();
    logic [31:0] a;
    req_ready      = ($urandom_range(0, 2) != 0);
    instr_ready    = ($urandom_range(0, 1) != 0);
    rsp_valid      = mem_busy && (mem_delay == 0);
    rsp_data       = $urandom;
    rsp_err        = ($urandom_range(0, 7) == 0);
    redirect_valid = ($urandom_range(0, 11) == 0);
    a = $urandom;
    a = {16'h8000, a[15:2], 2'b00};
    if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
    redirect_addr = a;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_valid"},   {31'd0, req_valid},   32'd0);
    chk({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr_fault"}, {31'd0, instr_fault}, 32'd0);
    chk({tag, "_instr"},       instr,                32'd0);
    chk({tag, "_instr_pc"},    instr_pc,             32'd0);
    chk({tag, "_pc_load"},     {31'd0, pc_load},     32'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    delivered = 0;
    reset     = 1'b1;
    idle_inputs();
    model_reset();

    // ---- reset state
    @(negedge clk);
    #1 check_reset_values("rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // ---- basic fetch: IDLE, REQ handshake, WAIT response, HOLD consume
    sample();
    chk("idle_no_req", {31'd0, req_valid}, 32'd0);
    @(negedge clk);
    req_ready = 1'b1;
    sample();
    chk("first_req_addr", req_addr, 32'h8000_0000);
    chk("first_req_pc_step", {31'd0, pc_load}, 32'd0);
    @(negedge clk);
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0050_0093;
    sample();
    @(negedge clk);
    rsp_valid = 1'b0; instr_ready = 1'b1;
    sample();
    chk("basic_valid", {31'd0, instr_valid}, 32'd1);
    chk("basic_instr", instr, 32'h0050_0093);
    chk("basic_pc", instr_pc, 32'h8000_0000);
    @(negedge clk);
    instr_ready = 1'b0;

    // ---- request stall: PC must hold for 5 cycles
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("stall_req_valid", {31'd0, req_valid}, 32'd1);
      chk("stall_req_addr", req_addr, 32'h8000_0004);
      chk("stall_pc", pc_addr, 32'h8000_0004);
      chk("stall_pc_load", {31'd0, pc_load}, 32'd1);
      @(negedge clk);
    end
    req_ready = 1'b1;
    sample();
    @(negedge clk);

    // ---- redirect while waiting, stale response discarded
    req_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'h8000_0100;
    sample();
    chk("redir_load_addr", pc_load_addr, 32'h8000_0100);
    @(negedge clk);
    redirect_valid = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    sample();
    @(negedge clk);
    rsp_valid = 1'b0; req_ready = 1'b1;
    sample();
    chk("stale_no_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_req_addr", req_addr, 32'h8000_0100);
    @(negedge clk);

    // ---- bus error response, decode stalls 4 cycles
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_err = 1'b1; rsp_data = $urandom;
    sample();
    @(negedge clk);
    rsp_valid = 1'b0; rsp_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("err_valid", {31'd0, instr_valid}, 32'd1);
      chk("err_fault", {31'd0, instr_fault}, 32'd1);
      chk("err_instr", instr, 32'h0000_0013);
      chk("err_pc", instr_pc, 32'h8000_0100);
      chk("err_no_req", {31'd0, req_valid}, 32'd0);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    sample();
    @(negedge clk);

    // ---- misaligned redirect target
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'h8000_0102;
    sample();
    @(negedge clk);
    redirect_valid = 1'b0; req_ready = 1'b1;
    sample();
    chk("mis_no_req", {31'd0, req_valid}, 32'd0);
    @(negedge clk);
    req_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'h8000_0200;
    sample();
    chk("mis_valid", {31'd0, instr_valid}, 32'd1);
    chk("mis_fault", {31'd0, instr_fault}, 32'd1);
    chk("mis_instr", instr, 32'h0000_0013);
    chk("mis_pc", instr_pc, 32'h8000_0102);
    @(negedge clk);
    redirect_valid = 1'b0; req_ready = 1'b1;
    sample();
    chk("redir_clears_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);

    // ---- asynchronous reset while waiting
    req_ready = 1'b0;
    sample();
    #2 reset = 1'b1;
    #1 check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sample();
    chk("post_rst_idle", {31'd0, req_valid}, 32'd0);
    @(negedge clk);
    sample();
    chk("post_rst_req", {31'd0, req_valid}, 32'd1);
    chk("post_rst_addr", req_addr, 32'h8000_0000);
    @(negedge clk);

    // ---- randomized traffic against the reference
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      sample();
      @(negedge clk);
    end
    chk("progress", {31'd0, (delivered > 50)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
